// File: rtl/ring_pkg.sv
`default_nettype none
// ============================================================================
// Module      : ring_pkg
// Description : Shared constants and FSM state encoding for the LED ring
//               frame arbiter (frame field widths, default gap and watchdog
//               lengths, arbiter state codes).
// Revision    : 1.0 - initial release
// ============================================================================
package ring_pkg;

    localparam int LED_COUNT          = 12;
    localparam int COLOUR_W           = 3;
    localparam int INTENSITY_W        = 8;

    // 60 us latch gap at 10 MHz, and the longest wait for the driver.
    localparam int DEF_LATCH_CYCLES   = 600;
    localparam int DEF_TIMEOUT_CYCLES = 65535;

    typedef logic [1:0] state_t;

    localparam state_t c_st_idle  = 2'd0;
    localparam state_t c_st_start = 2'd1;
    localparam state_t c_st_send  = 2'd2;
    localparam state_t c_st_latch = 2'd3;

endpackage
`default_nettype wire

// File: rtl/ring_grant_sel.sv
`default_nettype none
// ============================================================================
// Module      : ring_grant_sel
// Description : Winner selection between the two frame requesters.
//               Default build: fixed priority, port 0 over port 1.
//               With ROUND_ROBIN_EN defined: on a tie the port that did not
//               win last time is chosen; port 0 wins the first tie after
//               reset.
// Ports       : clk, res      - clock, synchronous active-high reset
//               req0, req1    - request levels
//               take          - a grant is being taken this cycle
//               any_req       - at least one request is pending
//               winner        - selected port (0 or 1)
// Revision    : 1.0 - initial release
// ============================================================================
module ring_grant_sel (
    input  logic clk,
    input  logic res,
    input  logic req0,
    input  logic req1,
    input  logic take,
    output logic any_req,
    output logic winner
);

    assign any_req = req0 | req1;

`ifdef ROUND_ROBIN_EN
    // Remembers the last port served. Resets to 1 so that port 0 takes
    // the first tie.
    logic r_last;

    always_ff @(posedge clk) begin
        if (res) begin
            r_last <= 1'b1;
        end else if (take) begin
            r_last <= winner;
        end
    end

    assign winner = (req0 & req1) ? ~r_last : req1;
`else
    // Fixed priority needs no history.
    logic w_unused;
    assign w_unused = &{1'b0, clk, res, take};

    assign winner = ~req0 & req1;
`endif

endmodule
`default_nettype wire

// File: rtl/ring_frame_arbiter.sv
`default_nettype none
// ============================================================================
// Module      : ring_frame_arbiter
// Description : Shares one WS2812B ring driver between two frame
//               requesters. Captures the winning frame, issues a single
//               drv_start, waits for drv_done under a watchdog, then holds
//               the line idle for the latch gap before the next frame.
//               Optional macro: ROUND_ROBIN_EN (alternate on ties instead of
//               fixed port-0 priority).
// Ports       : clk, res                       - clock, sync active-high reset
//               req/mask/colour/intensity 0,1  - requester frames (level req)
//               ack0, ack1                     - one-cycle capture pulses
//               drv_start                      - one-cycle driver kick
//               drv_mask/colour/intensity      - captured frame to driver
//               drv_done                       - driver finished (SEND only)
//               busy                           - not in IDLE
//               grant_id                       - port of current/last frame
//               timeout_err                    - sticky watchdog abort flag
// Revision    : 1.0 - initial release
// ============================================================================
module ring_frame_arbiter
    import ring_pkg::*;
#(
    parameter int LATCH_CYCLES   = DEF_LATCH_CYCLES,
    parameter int TIMEOUT_CYCLES = DEF_TIMEOUT_CYCLES,
    parameter int CNT_W          = 16
) (
    input  logic                   clk,
    input  logic                   res,

    input  logic                   req0,
    input  logic [LED_COUNT-1:0]   mask0,
    input  logic [COLOUR_W-1:0]    colour0,
    input  logic [INTENSITY_W-1:0] intensity0,
    output logic                   ack0,

    input  logic                   req1,
    input  logic [LED_COUNT-1:0]   mask1,
    input  logic [COLOUR_W-1:0]    colour1,
    input  logic [INTENSITY_W-1:0] intensity1,
    output logic                   ack1,

    output logic                   drv_start,
    output logic [LED_COUNT-1:0]   drv_mask,
    output logic [COLOUR_W-1:0]    drv_colour,
    output logic [INTENSITY_W-1:0] drv_intensity,
    input  logic                   drv_done,

    output logic                   busy,
    output logic                   grant_id,
    output logic                   timeout_err
);

    // Counter reload values; the counter runs N-1 down to 0, i.e. N cycles.
    localparam logic [CNT_W-1:0] c_latch_load   = CNT_W'(LATCH_CYCLES - 1);
    localparam logic [CNT_W-1:0] c_timeout_load = CNT_W'(TIMEOUT_CYCLES - 1);

    state_t                 r_state;
    logic [CNT_W-1:0]       r_cnt;
    logic                   r_ack0;
    logic                   r_ack1;
    logic                   r_drv_start;
    logic [LED_COUNT-1:0]   r_drv_mask;
    logic [COLOUR_W-1:0]    r_drv_colour;
    logic [INTENSITY_W-1:0] r_drv_intensity;
    logic                   r_busy;
    logic                   r_grant_id;
    logic                   r_timeout_err;

    logic                   w_any_req;
    logic                   w_winner;
    logic                   w_take;

    assign w_take = (r_state == c_st_idle) & w_any_req;

    ring_grant_sel u_grant_sel (
        .clk     (clk),
        .res     (res),
        .req0    (req0),
        .req1    (req1),
        .take    (w_take),
        .any_req (w_any_req),
        .winner  (w_winner)
    );

    always_ff @(posedge clk) begin
        if (res) begin
            r_state         <= c_st_idle;
            r_cnt           <= '0;
            r_ack0          <= 1'b0;
            r_ack1          <= 1'b0;
            r_drv_start     <= 1'b0;
            r_drv_mask      <= '0;
            r_drv_colour    <= '0;
            r_drv_intensity <= '0;
            r_busy          <= 1'b0;
            r_grant_id      <= 1'b0;
            r_timeout_err   <= 1'b0;
        end else begin
            // Pulses default low; each is raised for a single cycle below.
            r_ack0      <= 1'b0;
            r_ack1      <= 1'b0;
            r_drv_start <= 1'b0;

            case (r_state)
                c_st_idle: begin
                    if (w_any_req) begin
                        r_grant_id <= w_winner;
                        if (w_winner) begin
                            r_drv_mask      <= mask1;
                            r_drv_colour    <= colour1;
                            r_drv_intensity <= intensity1;
                            r_ack1          <= 1'b1;
                        end else begin
                            r_drv_mask      <= mask0;
                            r_drv_colour    <= colour0;
                            r_drv_intensity <= intensity0;
                            r_ack0          <= 1'b1;
                        end
                        r_busy  <= 1'b1;
                        r_state <= c_st_start;
                    end
                end

                c_st_start: begin
                    r_drv_start <= 1'b1;
                    r_cnt       <= c_timeout_load;
                    r_state     <= c_st_send;
                end

                c_st_send: begin
                    // drv_done has precedence, so a done coinciding with the
                    // last watchdog cycle still counts as success.
                    if (drv_done) begin
                        r_cnt   <= c_latch_load;
                        r_state <= c_st_latch;
                    end else if (r_cnt == '0) begin
                        r_timeout_err <= 1'b1;
                        r_cnt         <= c_latch_load;
                        r_state       <= c_st_latch;
                    end else begin
                        r_cnt <= r_cnt - 1'b1;
                    end
                end

                c_st_latch: begin
                    // Requests are not looked at here; level reqs simply
                    // remain pending until IDLE.
                    if (r_cnt == '0) begin
                        r_busy  <= 1'b0;
                        r_state <= c_st_idle;
                    end else begin
                        r_cnt <= r_cnt - 1'b1;
                    end
                end

                default: begin
                    r_busy  <= 1'b0;
                    r_state <= c_st_idle;
                end
            endcase
        end
    end

    assign ack0          = r_ack0;
    assign ack1          = r_ack1;
    assign drv_start     = r_drv_start;
    assign drv_mask      = r_drv_mask;
    assign drv_colour    = r_drv_colour;
    assign drv_intensity = r_drv_intensity;
    assign busy          = r_busy;
    assign grant_id      = r_grant_id;
    assign timeout_err   = r_timeout_err;

endmodule
`default_nettype wire

// File: tb/tb_ring_frame_arbiter.sv
`default_nettype none
// ============================================================================
// Module      : tb_ring_frame_arbiter
// Description : Self-checking bench for ring_frame_arbiter (default build,
//               fixed priority). Stimulus pushes expected grants into
//               queues; a negedge monitor pops and compares whenever the
//               DUT pulses an ack or drv_start.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_ring_frame_arbiter;

    localparam int LATCH_CYCLES   = 8;
    localparam int TIMEOUT_CYCLES = 16;
    localparam int CNT_W          = 16;

    typedef struct {
        logic        port;
        logic [11:0] mask;
        logic [2:0]  colour;
        logic [7:0]  intensity;
    } frame_t;

    logic        clk;
    logic        res;
    logic        req0;
    logic [11:0] mask0;
    logic [2:0]  colour0;
    logic [7:0]  intensity0;
    logic        ack0;
    logic        req1;
    logic [11:0] mask1;
    logic [2:0]  colour1;
    logic [7:0]  intensity1;
    logic        ack1;
    logic        drv_start;
    logic [11:0] drv_mask;
    logic [2:0]  drv_colour;
    logic [7:0]  drv_intensity;
    logic        drv_done;
    logic        busy;
    logic        grant_id;
    logic        timeout_err;

    int     n_cmp;
    int     n_err;
    int     n_issued;
    int     n_ack_seen;
    int     n_start_seen;
    logic   ack_q[$];
    frame_t start_q[$];
    frame_t m_f;
    logic   m_p;

    ring_frame_arbiter #(
        .LATCH_CYCLES   (LATCH_CYCLES),
        .TIMEOUT_CYCLES (TIMEOUT_CYCLES),
        .CNT_W          (CNT_W)
    ) dut (
        .clk           (clk),
        .res           (res),
        .req0          (req0),
        .mask0         (mask0),
        .colour0       (colour0),
        .intensity0    (intensity0),
        .ack0          (ack0),
        .req1          (req1),
        .mask1         (mask1),
        .colour1       (colour1),
        .intensity1    (intensity1),
        .ack1          (ack1),
        .drv_start     (drv_start),
        .drv_mask      (drv_mask),
        .drv_colour    (drv_colour),
        .drv_intensity (drv_intensity),
        .drv_done      (drv_done),
        .busy          (busy),
        .grant_id      (grant_id),
        .timeout_err   (timeout_err)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #100000;
        $display("FAIL global_timeout: simulation did not finish in time");
        $fatal(1, "global timeout");
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: actual=%0h required=%0h", name, act, exp);
        end
    endtask

    task automatic expect_frame(input logic p, input logic [11:0] m,
                                input logic [2:0] c, input logic [7:0] i);
        frame_t f;
        f.port = p; f.mask = m; f.colour = c; f.intensity = i;
        ack_q.push_back(p);
        start_q.push_back(f);
        n_issued++;
    endtask

    // Scoreboard monitor: pops on every ack / drv_start pulse.
    always @(negedge clk) begin
        if (!res) begin
            if (ack0 || ack1) begin
                n_ack_seen++;
                check("ack_exclusive", {31'd0, ack0 & ack1}, 32'd0);
                if (ack_q.size() == 0) begin
                    n_cmp++; n_err++;
                    $display("FAIL unexpected_ack: actual ack0=%0b ack1=%0b required none", ack0, ack1);
                end else begin
                    m_p = ack_q.pop_front();
                    check("ack_port", {31'd0, ack1}, {31'd0, m_p});
                end
            end
            if (drv_start) begin
                n_start_seen++;
                if (start_q.size() == 0) begin
                    n_cmp++; n_err++;
                    $display("FAIL unexpected_start: actual drv_start=1 required 0");
                end else begin
                    m_f = start_q.pop_front();
                    check("start_grant_id",  {31'd0, grant_id},     {31'd0, m_f.port});
                    check("start_mask",      {20'd0, drv_mask},     {20'd0, m_f.mask});
                    check("start_colour",    {29'd0, drv_colour},   {29'd0, m_f.colour});
                    check("start_intensity", {24'd0, drv_intensity}, {24'd0, m_f.intensity});
                    check("start_busy",      {31'd0, busy},         32'd1);
                end
            end
        end
    end

    task automatic wait_ack(input logic p);
        int k;
        for (k = 0; k < 64; k++) begin
            @(negedge clk);
            if ((p == 1'b0 && ack0) || (p == 1'b1 && ack1)) break;
        end
        check("ack_arrived", {31'd0, (k < 64)}, 32'd1);
        if (p == 1'b0) req0 = 1'b0; else req1 = 1'b0;
    endtask

    task automatic wait_start();
        int k;
        for (k = 0; k < 64; k++) begin
            @(negedge clk);
            if (drv_start) break;
        end
        check("start_arrived", {31'd0, (k < 64)}, 32'd1);
    endtask

    task automatic wait_idle();
        int k;
        for (k = 0; k < 200; k++) begin
            @(negedge clk);
            if (!busy) break;
        end
        check("idle_reached", {31'd0, (k < 200)}, 32'd1);
    endtask

    // Single-edge drv_done pulse; returns just after the sampling edge.
    task automatic pulse_done();
        @(posedge clk); #1 drv_done = 1'b1;
        @(posedge clk); #1 drv_done = 1'b0;
    endtask

    initial begin
        int j;
        n_cmp = 0; n_err = 0; n_issued = 0; n_ack_seen = 0; n_start_seen = 0;
        res = 1'b1; drv_done = 1'b0;
        req0 = 1'b0; mask0 = '0; colour0 = '0; intensity0 = '0;
        req1 = 1'b0; mask1 = '0; colour1 = '0; intensity1 = '0;

        // ---- reset state ----
        repeat (3) @(posedge clk);
        @(negedge clk);
        check("rst_ack0", {31'd0, ack0}, 32'd0);
        check("rst_ack1", {31'd0, ack1}, 32'd0);
        check("rst_drv_start", {31'd0, drv_start}, 32'd0);
        check("rst_drv_mask", {20'd0, drv_mask}, 32'd0);
        check("rst_busy", {31'd0, busy}, 32'd0);
        check("rst_timeout_err", {31'd0, timeout_err}, 32'd0);
        @(posedge clk); #1 res = 1'b0;

        // ---- single request, latency and latch length ----
        @(posedge clk); #1;
        mask0 = 12'hA5A; colour0 = 3'd5; intensity0 = 8'h40; req0 = 1'b1;
        expect_frame(1'b0, 12'hA5A, 3'd5, 8'h40);
        @(negedge clk);
        check("t1_ack_before_edge", {31'd0, ack0}, 32'd0);
        @(negedge clk);
        check("t1_ack_latency", {31'd0, ack0}, 32'd1);
        check("t1_busy", {31'd0, busy}, 32'd1);
        req0 = 1'b0;
        @(negedge clk);
        check("t1_start_latency", {31'd0, drv_start}, 32'd1);
        check("t1_ack_one_cycle", {31'd0, ack0}, 32'd0);
        @(negedge clk);
        check("t1_start_one_cycle", {31'd0, drv_start}, 32'd0);
        repeat (2) @(negedge clk);
        pulse_done();
        j = 0;
        while (j < 100) begin
            @(negedge clk);
            if (!busy) break;
            j++;
        end
        check("t1_latch_len", j, LATCH_CYCLES);
        check("t1_mask_held", {20'd0, drv_mask}, 32'h0000_0A5A);

        // ---- simultaneous requests, fixed priority, latch gap ----
        @(posedge clk); #1;
        mask0 = 12'h123; colour0 = 3'd1; intensity0 = 8'h10; req0 = 1'b1;
        mask1 = 12'hFED; colour1 = 3'd7; intensity1 = 8'hE0; req1 = 1'b1;
        expect_frame(1'b0, 12'h123, 3'd1, 8'h10);
        expect_frame(1'b1, 12'hFED, 3'd7, 8'hE0);
        wait_ack(1'b0);
        wait_start();
        repeat (3) @(negedge clk);
        pulse_done();
        j = 0;
        while (j < 100) begin
            @(negedge clk);
            if (ack1) break;
            j++;
        end
        check("t2_gap_to_ack1", j, LATCH_CYCLES + 1);
        req1 = 1'b0;
        wait_start();
        pulse_done();
        wait_idle();

        // ---- port 1 alone; port 0 raised and dropped while busy ----
        @(posedge clk); #1;
        mask1 = 12'h0C3; colour1 = 3'd6; intensity1 = 8'h99; req1 = 1'b1;
        expect_frame(1'b1, 12'h0C3, 3'd6, 8'h99);
        wait_ack(1'b1);
        wait_start();
        @(posedge clk); #1 req0 = 1'b1; mask0 = 12'h777;
        repeat (2) @(posedge clk);
        #1 req0 = 1'b0;
        pulse_done();
        wait_idle();
        repeat (4) @(negedge clk);
        check("t3_withdrawn_no_ack", n_ack_seen, n_issued);
        check("t3_withdrawn_no_start", n_start_seen, n_issued);

        // ---- stray drv_done while idle ----
        pulse_done();
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            check("t4_idle_busy", {31'd0, busy}, 32'd0);
            check("t4_idle_start", {31'd0, drv_start}, 32'd0);
        end

        // ---- watchdog expiry ----
        @(posedge clk); #1;
        mask0 = 12'h0F0; colour0 = 3'd3; intensity0 = 8'h80; req0 = 1'b1;
        expect_frame(1'b0, 12'h0F0, 3'd3, 8'h80);
        wait_ack(1'b0);
        wait_start();
        j = 0;
        while (j < 100) begin
            @(negedge clk);
            j++;
            if (timeout_err) break;
        end
        check("t5_timeout_delay", j, TIMEOUT_CYCLES);
        check("t5_latch_after_timeout", {31'd0, busy}, 32'd1);
        wait_idle();
        repeat (3) @(negedge clk);
        check("t5_timeout_sticky", {31'd0, timeout_err}, 32'd1);

        // ---- reset mid-SEND with a pending port-0 request ----
        @(posedge clk); #1;
        mask1 = 12'h111; colour1 = 3'd1; intensity1 = 8'h11; req1 = 1'b1;
        expect_frame(1'b1, 12'h111, 3'd1, 8'h11);
        wait_ack(1'b1);
        wait_start();
        repeat (3) @(negedge clk);
        @(posedge clk); #1;
        res = 1'b1;
        mask0 = 12'h222; colour0 = 3'd2; intensity0 = 8'h22; req0 = 1'b1;
        expect_frame(1'b0, 12'h222, 3'd2, 8'h22);
        @(posedge clk); #1 res = 1'b0;
        @(negedge clk);
        check("t6_rst_busy", {31'd0, busy}, 32'd0);
        check("t6_rst_start", {31'd0, drv_start}, 32'd0);
        check("t6_rst_ack0", {31'd0, ack0}, 32'd0);
        check("t6_rst_timeout_err", {31'd0, timeout_err}, 32'd0);
        check("t6_rst_mask", {20'd0, drv_mask}, 32'd0);
        check("t6_rst_colour", {29'd0, drv_colour}, 32'd0);
        check("t6_rst_intensity", {24'd0, drv_intensity}, 32'd0);
        check("t6_rst_grant_id", {31'd0, grant_id}, 32'd0);
        wait_ack(1'b0);
        wait_start();
        pulse_done();
        wait_idle();

        // ---- drv_done on the final watchdog cycle counts as success ----
        @(posedge clk); #1;
        mask0 = 12'h333; colour0 = 3'd4; intensity0 = 8'h33; req0 = 1'b1;
        expect_frame(1'b0, 12'h333, 3'd4, 8'h33);
        wait_ack(1'b0);
        wait_start();
        repeat (TIMEOUT_CYCLES - 1) @(negedge clk);
        drv_done = 1'b1;
        @(posedge clk); #1 drv_done = 1'b0;
        wait_idle();
        check("t7_coincide_no_timeout", {31'd0, timeout_err}, 32'd0);

        // ---- final accounting ----
        repeat (4) @(negedge clk);
        check("end_ack_count", n_ack_seen, n_issued);
        check("end_start_count", n_start_seen, n_issued);
        check("end_ack_q_empty", ack_q.size(), 0);
        check("end_start_q_empty", start_q.size(), 0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/ring_frame_arbiter.md
Name: ring_frame_arbiter

Overview:
- Shares the single WS2812B LED ring driver between two frame requesters: port 0 is the user/controller path and port 1 is an animation/overlay path.
- Captures one requester's frame (led mask, colour, intensity) and sequences one driver transfer with a start pulse, waiting for done.
- Enforces the WS2812B latch gap (line idle) between frames and flags a hung driver with a watchdog.
- Sits between the controller and the LED ring driver in the top-level wrapper.

Parameters:
- LATCH_CYCLES, 600, minimum idle cycles after each frame (60 us at 10 MHz); legal range ≥2.
- TIMEOUT_CYCLES, 65535, maximum cycles to wait for drv_done before aborting; legal range ≥2.
- CNT_W, 16, width of the shared gap/watchdog counter; must hold max(LATCH_CYCLES, TIMEOUT_CYCLES).

Ports:
- clk  in  1  system clock
- res  in  1  synchronous reset, active high
- req0  in  1  frame request, port 0 (level, held until ack0)
- mask0  in  12  LED on-mask, port 0
- colour0  in  3  colour select, port 0
- intensity0  in  8  intensity, port 0
- ack0  out  1  one-cycle pulse: port 0 frame captured
- req1, mask1, colour1, intensity1, ack1  as port 0, for port 1
- drv_start  out  1  one-cycle start pulse to driver
- drv_mask  out  12  captured mask (registered)
- drv_colour  out  3  captured colour (registered)
- drv_intensity  out  8  captured intensity (registered)
- drv_done  in  1  driver finished shifting frame (pulse or level, sampled in SEND only)
- busy  out  1  high in every state except IDLE
- grant_id  out  1  port owning the current or last frame
- timeout_err  out  1  sticky; set on watchdog abort, cleared only by res

Behaviour:
- One clock domain; all outputs registered.
- Reset: state=IDLE, counter=0, and ack0, ack1, drv_start, drv_mask, drv_colour, drv_intensity, grant_id, timeout_err, busy all 0. Reset mid-transfer aborts immediately; no start pulse follows reset.
- FSM states: IDLE, START, SEND, LATCH.
- IDLE, when any reqN is high at an edge:
  - Pick the winner (see Arbitration).
  - Capture the winner's mask/colour/intensity into the drv_* registers and set grant_id.
  - Pulse ackN high for the next cycle, then go to START.
  - No request: stay in IDLE.
- START: drv_start=1 for exactly one cycle; load counter=TIMEOUT_CYCLES-1; go to SEND.
- SEND: decrement counter each cycle.
  - drv_done=1: load counter=LATCH_CYCLES-1, go to LATCH.
  - Counter reaches 0 without drv_done: set timeout_err, load the latch count, go to LATCH.
  - drv_done in the same cycle as counter=0: treat as success, timeout_err unchanged.
- LATCH: decrement counter; at 0 go to IDLE. New requests are ignored, not lost: level reqs stay pending.
- Latency: req sampled at edge E gives ack at E+1 and drv_start at E+2. Back-to-back frames are separated by at least LATCH_CYCLES+1 idle cycles after drv_done.
- Handshake:
  - The requester must drop reqN in the cycle ackN is high. A req still high the cycle after ack is a new request.
  - A req dropped before ack is withdrawn silently.
  - Data must be stable while req is high; only the ack-edge values are used.
- drv_* data stays stable from capture until the next capture; it does not change in SEND or LATCH.
- drv_done outside SEND is ignored.

Arbitration:
- Default (fixed priority): port 0 wins when both reqs are high.

Optional Feature:
- Macro ROUND_ROBIN_EN.
- Defined: when both ports request, the port not equal to the last grant_id wins; after reset, port 0 wins first. A single requester always wins.
- Undefined: fixed priority, port 0 over port 1; port 1 can be starved by continuous port 0 requests, which is accepted.

Decomposition:
- Shared package ring_pkg holds:
  - the FSM state encoding typedef (IDLE/START/SEND/LATCH);
  - LED_COUNT=12, COLOUR_W=3, INTENSITY_W=8;
  - default LATCH_CYCLES and TIMEOUT_CYCLES constants.
- One natural sub-module, ring_grant_sel: the combinational winner selection plus the last-grant register used under ROUND_ROBIN_EN. The FSM and counter stay in the top module.

Test Plan:
- Single request: req0 with mask=12'hA5A, colour=3'd5, intensity=8'h40, held until ack → ack0 one cycle later; drv_start the cycle after that; drv_* = A5A/5/40; grant_id=0; busy high until LATCH completes.
- Simultaneous req0 and req1 → fixed priority: port 0 served, then port 1 after drv_done + LATCH_CYCLES. With ROUND_ROBIN_EN: 0, 1, 0, 1 alternation while both are held.
- Latch gap: drv_done at cycle T; req1 held from T → ack1 no earlier than T+LATCH_CYCLES+1; exactly one drv_start per ack.
- Watchdog: TIMEOUT_CYCLES=16, drv_done never asserted → timeout_err rises 16 cycles after drv_start, FSM passes through LATCH back to IDLE, timeout_err stays 1 until res.
- Reset mid-SEND: assert res for 1 cycle → all outputs 0 the next cycle, no drv_start; a pending req0 is then served normally.
- Edge cases: req0 dropped before ack → no ack, no drv_start. Stray drv_done while IDLE → ignored. drv_done coinciding with watchdog expiry → no timeout_err.
